// File: rtl/vector_memory_arbiter_if.sv
// Host port bundle for vector_memory_arbiter.
//
// Handshake: a host request transfers on every cycle where hostReqValid and
// hostReqReady are both 1. While hostReqValid=1 and hostReqReady=0 the host
// keeps hostWriteEnable/hostAddress/hostWriteData stable; it may also drop
// hostReqValid before acceptance. hostReqReady is combinational. A read
// produces a one-cycle hostRspValid pulse on the following cycle; writes
// produce no response.
interface vector_memory_arbiter_if #(
  parameter int ADDRESS_WIDTH = 19,
  parameter int WIDTH         = 114
);
  logic                     hostReqValid;
  logic                     hostReqReady;
  logic                     hostWriteEnable;
  logic [ADDRESS_WIDTH-1:0] hostAddress;
  logic [WIDTH-1:0]         hostWriteData;
  logic                     hostRspValid;
  logic [WIDTH-1:0]         hostRspData;

  modport master (
    output hostReqValid, hostWriteEnable, hostAddress, hostWriteData,
    input  hostReqReady, hostRspValid, hostRspData
  );

  modport slave (
    input  hostReqValid, hostWriteEnable, hostAddress, hostWriteData,
    output hostReqReady, hostRspValid, hostRspData
  );
endinterface

// File: rtl/vector_memory_arbiter.sv
// vector_memory_arbiter: shares the single-port vector data memory between
// the CPU Memory stage (priority requester) and a host port. The host wait is
// bounded: after MAX_WAIT consecutive lost cycles the CPU is frozen for one
// cycle (cpuStall) and the host is served.
// Optional feature macro: ARB_STATS_EN (host grant / forced-cycle counters).
// debugState (1 = FORCE) and debugWaitCount expose the internal FSM state.
module vector_memory_arbiter #(
  parameter int DATA_WIDTH    = 19,
  parameter int VECTOR_SIZE   = 6,
  parameter int ADDRESS_WIDTH = 19,
  parameter int MAX_WAIT      = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                cpuReq,
  input  logic                                cpuWriteEnable,
  input  logic [ADDRESS_WIDTH-1:0]            cpuAddress,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   cpuWriteData,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   cpuReadData,
  output logic                                cpuStall,
  vector_memory_arbiter_if.slave              host,
  output logic                                memWriteEnable,
  output logic [ADDRESS_WIDTH-1:0]            memAddress,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   memWriteData,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   memReadData,
  output logic [15:0]                         statGrantCount,
  output logic [15:0]                         statForceCount,
  output logic                                debugState,
  output logic [3:0]                          debugWaitCount
);

  localparam int W = DATA_WIDTH * VECTOR_SIZE;
  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  typedef enum logic {
    IDLE  = 1'b0,
    FORCE = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   wait_count;
  logic [3:0]   count_next;
  logic         host_grant;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;

  // Grant decision, wait counting and next-state selection.
  always_comb begin
    state_next = state;
    count_next = wait_count;
    host_grant = host.hostReqValid && ((state == FORCE) || !cpuReq);
    case (state)
      IDLE: begin
        if (!host.hostReqValid || host_grant) begin
          count_next = '0;
        end else begin
          count_next = wait_count + 4'd1;
          // The host has now lost MAX_WAIT cycles in a row: freeze the CPU next cycle.
          if (count_next == MAX_WAIT_L) begin
            state_next = FORCE;
          end
        end
      end
      FORCE: begin
        state_next = IDLE;
        count_next = '0;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Memory port mux; a frozen CPU request never reaches the memory.
  always_comb begin
    memAddress     = cpuAddress;
    memWriteData   = cpuWriteData;
    memWriteEnable = cpuReq && cpuWriteEnable && (state != FORCE);
    if (host_grant) begin
      memAddress     = host.hostAddress;
      memWriteData   = host.hostWriteData;
      memWriteEnable = host.hostWriteEnable;
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_count <= '0;
    end else begin
      state      <= state_next;
      wait_count <= count_next;
    end
  end

  // Host read response: capture memory data on a granted read, pulse valid next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= host_grant && !host.hostWriteEnable;
      if (host_grant && !host.hostWriteEnable) begin
        rsp_data <= memReadData;
      end
    end
  end

  assign cpuReadData       = memReadData;
  assign cpuStall          = (state == FORCE);
  assign host.hostReqReady = host_grant;
  assign host.hostRspValid = rsp_valid;
  assign host.hostRspData  = rsp_data;
  assign debugState        = (state == FORCE);
  assign debugWaitCount    = wait_count;

`ifdef ARB_STATS_EN
  logic [15:0] grant_count;
  logic [15:0] force_count;

  // Saturating counters of host grants and of cycles spent in FORCE.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count <= '0;
      force_count <= '0;
    end else begin
      if (host_grant && (grant_count != 16'hFFFF)) begin
        grant_count <= grant_count + 16'd1;
      end
      if ((state == FORCE) && (force_count != 16'hFFFF)) begin
        force_count <= force_count + 16'd1;
      end
    end
  end

  assign statGrantCount = grant_count;
  assign statForceCount = force_count;
`else
  assign statGrantCount = '0;
  assign statForceCount = '0;
`endif

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// Testbench for vector_memory_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_vector_memory_arbiter;

  localparam int DW = 19;
  localparam int VS = 6;
  localparam int AW = 19;
  localparam int MAX_WAIT = 4;
  localparam int W = DW * VS;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          cpuReq;
  logic          cpuWriteEnable;
  logic [AW-1:0] cpuAddress;
  logic [W-1:0]  cpuWriteData;
  logic [W-1:0]  cpuReadData;
  logic          cpuStall;
  logic          memWriteEnable;
  logic [AW-1:0] memAddress;
  logic [W-1:0]  memWriteData;
  logic [W-1:0]  memReadData;
  logic [15:0]   statGrantCount;
  logic [15:0]   statForceCount;
  logic          debugState;
  logic [3:0]    debugWaitCount;

  vector_memory_arbiter_if #(.ADDRESS_WIDTH(AW), .WIDTH(W)) host_bus ();

  vector_memory_arbiter #(
    .DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cpuReq         (cpuReq),
    .cpuWriteEnable (cpuWriteEnable),
    .cpuAddress     (cpuAddress),
    .cpuWriteData   (cpuWriteData),
    .cpuReadData    (cpuReadData),
    .cpuStall       (cpuStall),
    .host           (host_bus.slave),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .memReadData    (memReadData),
    .statGrantCount (statGrantCount),
    .statForceCount (statForceCount),
    .debugState     (debugState),
    .debugWaitCount (debugWaitCount)
  );

  // Memory instance: combinational read, posedge write; low 8 address bits index it.
  logic [W-1:0] mem_array [256];
  assign memReadData = mem_array[memAddress[7:0]];
  always @(posedge clock) begin
    if (memWriteEnable) mem_array[memAddress[7:0]] <= memWriteData;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;
  logic check_en = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  logic [W-1:0] m_mem [256];
  logic [W-1:0] exp_q [$];
  int           m_lost   = 0;   // consecutive cycles the host has lost
  bit           m_rsp_v  = 0;
  int           m_grants = 0;
  int           m_forces = 0;

  // One compare process: checks every cycle at the falling edge, then advances the model.
  always @(negedge clock) begin
    if (check_en) begin
      bit            f, g, we;
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      f  = (m_lost == MAX_WAIT);
      g  = host_bus.hostReqValid && (f || !cpuReq);
      we = g ? host_bus.hostWriteEnable : (!f && cpuReq && cpuWriteEnable);
      a  = g ? host_bus.hostAddress : cpuAddress;
      d  = g ? host_bus.hostWriteData : cpuWriteData;

      chk("hostReqReady", host_bus.hostReqReady, g);
      chk("cpuStall", cpuStall, f);
      chk("memWriteEnable", memWriteEnable, we);
      chk("memAddress", memAddress, a);
      chk("memWriteData", memWriteData, d);
      chk("cpuReadData", cpuReadData, m_mem[a[7:0]]);
      chk("hostRspValid", host_bus.hostRspValid, m_rsp_v);
      if (m_rsp_v) begin
        if (exp_q.size() == 0) begin
          chk("rsp_queue_empty", 1, 0);
        end else begin
          chk("hostRspData", host_bus.hostRspData, exp_q.pop_front());
        end
      end
      chk("debugState", debugState, f);
      chk("debugWaitCount", debugWaitCount, 4'(m_lost));
`ifdef ARB_STATS_EN
      chk("statGrantCount", statGrantCount, 16'(m_grants));
      chk("statForceCount", statForceCount, 16'(m_forces));
`else
      chk("statGrantCount", statGrantCount, 0);
      chk("statForceCount", statForceCount, 0);
`endif

      if (reset) begin
        m_lost = 0; m_rsp_v = 0; m_grants = 0; m_forces = 0;
        exp_q.delete();
      end else begin
        m_rsp_v = g && !host_bus.hostWriteEnable;
        if (m_rsp_v) exp_q.push_back(m_mem[host_bus.hostAddress[7:0]]);
        if (f || !host_bus.hostReqValid || g) m_lost = 0;
        else m_lost = m_lost + 1;
        if (g && m_grants < 65535) m_grants = m_grants + 1;
        if (f && m_forces < 65535) m_forces = m_forces + 1;
      end
      if (we) m_mem[a[7:0]] = d;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    cpuReq = 0; cpuWriteEnable = 0; cpuAddress = '0; cpuWriteData = '0;
    host_bus.hostReqValid = 0; host_bus.hostWriteEnable = 0;
    host_bus.hostAddress = '0; host_bus.hostWriteData = '0;
  endtask

  task automatic set_cpu(bit we, logic [AW-1:0] a, logic [W-1:0] d);
    cpuReq = 1; cpuWriteEnable = we; cpuAddress = a; cpuWriteData = d;
  endtask

  task automatic set_host(bit we, logic [AW-1:0] a, logic [W-1:0] d);
    host_bus.hostReqValid = 1; host_bus.hostWriteEnable = we;
    host_bus.hostAddress = a; host_bus.hostWriteData = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v, c1, c2, h, s;
    bit accepted_prev;
    for (int i = 0; i < 256; i++) begin
      mem_array[i] = '0;
      m_mem[i] = '0;
    end
    v = rand_word(); c1 = rand_word(); c2 = rand_word(); h = rand_word(); s = rand_word();
    reset = 1;
    set_idle();
    @(posedge clock);
    #1;
    check_en = 1;
    #2;
    chk("rst_cpuStall", cpuStall, 0);
    chk("rst_hostRspValid", host_bus.hostRspValid, 0);
    chk("rst_hostRspData", host_bus.hostRspData, 0);
    chk("rst_waitCount", debugWaitCount, 0);
    chk("rst_statGrant", statGrantCount, 0);
    chk("rst_statForce", statForceCount, 0);

    // Host write then read of 0x10 with the CPU idle.
    next_cycle(); reset = 0; set_idle(); set_host(1, 19'h10, v);
    #2 chk("a_wr_ready", host_bus.hostReqReady, 1);
    next_cycle(); set_host(0, 19'h10, '0);
    #2 chk("a_rd_ready", host_bus.hostReqReady, 1);
    chk("a_no_rsp_for_write", host_bus.hostRspValid, 0);
    next_cycle(); set_idle();
    #2 chk("a_rsp_valid", host_bus.hostRspValid, 1);
    chk("a_rsp_data", host_bus.hostRspData, v);
    next_cycle();
    #2 chk("a_rsp_pulse_end", host_bus.hostRspValid, 0);

    // CPU stores every cycle while a host write waits: four losses, then FORCE.
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_cpu(1, 19'h30, c1); set_host(1, 19'h31, h);
      #2 chk("b_lost_ready", host_bus.hostReqReady, 0);
      chk("b_lost_stall", cpuStall, 0);
    end
    next_cycle(); cpuWriteData = c2;
    #2 chk("b_force_stall", cpuStall, 1);
    chk("b_force_ready", host_bus.hostReqReady, 1);
    chk("b_force_we", memWriteEnable, 1);
    chk("b_force_addr", memAddress, 19'h31);
    chk("b_force_data", memWriteData, h);
    next_cycle(); set_idle();
    #2 chk("b_after_stall", cpuStall, 0);
    chk("b_cpu_word_kept", mem_array[8'h30], c1);
    chk("b_host_word", mem_array[8'h31], h);

    // Host withdraws after three losses; the count restarts from zero.
    for (int k = 0; k < 3; k++) begin
      next_cycle(); set_cpu(0, 19'h50, '0); set_host(0, 19'h40, '0);
      #2 chk("c_lost_ready", host_bus.hostReqReady, 0);
    end
    next_cycle(); host_bus.hostReqValid = 0;
    #2 chk("c_withdraw_stall", cpuStall, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); host_bus.hostReqValid = 1;
      #2 chk("c_relost_ready", host_bus.hostReqReady, 0);
      chk("c_relost_stall", cpuStall, 0);
    end
    next_cycle();
    #2 chk("c_force_stall", cpuStall, 1);
    chk("c_force_ready", host_bus.hostReqReady, 1);
    next_cycle(); set_idle();
    #2 chk("c_rsp_valid", host_bus.hostRspValid, 1);

    // CPU store to 0x20, then host read of 0x20.
    next_cycle(); set_idle(); set_cpu(1, 19'h20, s);
    next_cycle(); set_idle(); set_host(0, 19'h20, '0);
    #2 chk("d_ready", host_bus.hostReqReady, 1);
    next_cycle(); set_idle();
    #2 chk("d_rsp_valid", host_bus.hostRspValid, 1);
    chk("d_rsp_data", host_bus.hostRspData, s);

    // Reset asserted in the FORCE cycle of a granted host read.
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_cpu(0, 19'h21, '0); set_host(0, 19'h20, '0);
    end
    next_cycle(); reset = 1;
    #2 chk("e_force_stall", cpuStall, 1);
    next_cycle(); reset = 0; set_idle();
    #2 chk("e_stall_cleared", cpuStall, 0);
    chk("e_rsp_dropped", host_bus.hostRspValid, 0);
    chk("e_count_cleared", debugWaitCount, 0);

    // Three normal grants and one forced grant.
    for (int k = 0; k < 3; k++) begin
      next_cycle(); set_idle(); set_host(1, AW'(8'h60 + k), rand_word());
      #2 chk("f_normal_ready", host_bus.hostReqReady, 1);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_cpu(0, 19'h22, '0); set_host(1, 19'h70, rand_word());
    end
    next_cycle();
    #2 chk("f_force_stall", cpuStall, 1);
    next_cycle(); set_idle();
`ifdef ARB_STATS_EN
    #2 chk("f_stat_grant", statGrantCount, 4);
    chk("f_stat_force", statForceCount, 1);
`else
    #2 chk("f_stat_grant", statGrantCount, 0);
    chk("f_stat_force", statForceCount, 0);
`endif

    // Randomized traffic; host fields stay stable while a request waits.
    accepted_prev = 0;
    for (int n = 0; n < 3000; n++) begin
      bit keep;
      next_cycle();
      reset = ($urandom_range(0, 299) == 0);
      cpuReq = ($urandom_range(0, 99) < 65);
      cpuWriteEnable = $urandom_range(0, 1);
      cpuAddress = AW'($urandom_range(0, 524287));
      cpuWriteData = rand_word();
      keep = host_bus.hostReqValid && !accepted_prev && ($urandom_range(0, 9) != 0);
      if (!keep) begin
        host_bus.hostReqValid = ($urandom_range(0, 99) < 55);
        host_bus.hostWriteEnable = $urandom_range(0, 1);
        host_bus.hostAddress = AW'($urandom_range(0, 524287));
        host_bus.hostWriteData = rand_word();
      end
      #2 accepted_prev = host_bus.hostReqReady;
    end

    next_cycle();
    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
